// File: rtl/bram_master.sv
// rtl/bram_master.sv - burst master driving a single BRAM port (write and read bursts); optional macro BRAM_MASTER_BOUNDS_EN
`ifndef DATA_BIT_NUM
`define DATA_BIT_NUM 16
`endif

module bram_master #(
    parameter int DW    = `DATA_BIT_NUM,
    parameter int DEPTH = 81920
) (
    input  logic          i_clk_BMST,
    input  logic          i_rst_BMST,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_write,
    input  logic [31:0]   i_req_addr,
    input  logic [7:0]    i_req_len,
    input  logic          i_wdata_valid,
    output logic          o_wdata_ready,
    input  logic [DW-1:0] i_wdata,
    output logic          o_rdata_valid,
    input  logic          i_rdata_ready,
    output logic [DW-1:0] o_rdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_bram_en,
    output logic          o_bram_rst,
    output logic [3:0]    o_bram_we,
    output logic [31:0]   o_bram_addr,
    output logic [DW-1:0] o_bram_wdata,
    input  logic [DW-1:0] i_bram_rdata
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WRITE    = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_DATA  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
    localparam logic [2:0] ERR      = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_cur_addr;
    logic [7:0]  r_beats;
    logic        r_armed;   // keeps req_ready low until the first edge after reset release

    logic w_accept;
    logic w_wr_beat;
    logic w_rd_hs;
    logic w_rd_next;
    logic w_oob;

    assign w_accept  = i_req_valid && o_req_ready;
    assign w_wr_beat = (r_state == WRITE) && i_wdata_valid;
    assign w_rd_hs   = (r_state == RD_DATA) && i_rdata_ready;
    assign w_rd_next = w_rd_hs && (r_beats != 8'd0);

`ifdef BRAM_MASTER_BOUNDS_EN
    assign w_oob = ({1'b0, i_req_addr} + {25'd0, i_req_len} + 33'd1) > 33'(DEPTH);
    assign o_err = (r_state == ERR);
`else
    assign w_oob = 1'b0;
    assign o_err = 1'b0;
`endif

    // Handshake and status flags decoded straight from the state register
    always_comb begin
        o_req_ready   = (r_state == IDLE) && r_armed;
        o_busy        = (r_state != IDLE);
        o_done        = (r_state == DONE);
        o_wdata_ready = (r_state == WRITE);
        o_rdata_valid = (r_state == RD_DATA);
        // BRAM output register holds between enabled reads, so passing it through keeps rdata stable in a stall
        o_rdata       = (r_state == RD_DATA) ? i_bram_rdata : '0;
        o_bram_rst    = ~i_rst_BMST;
    end

    // BRAM port drive; a read handshake with beats left prefetches the next word in the same cycle
    always_comb begin
        o_bram_en    = w_wr_beat || (r_state == RD_ISSUE) || w_rd_next;
        o_bram_we    = w_wr_beat ? 4'b1111 : 4'b0000;
        o_bram_addr  = w_rd_next ? (r_cur_addr + 32'd1) : r_cur_addr;
        o_bram_wdata = w_wr_beat ? i_wdata : '0;
    end

    // Burst sequencing: address/beat bookkeeping and state transitions
    always_ff @(posedge i_clk_BMST or negedge i_rst_BMST) begin
        if (!i_rst_BMST) begin
            r_state    <= IDLE;
            r_cur_addr <= 32'd0;
            r_beats    <= 8'd0;
            r_armed    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cur_addr <= i_req_addr;
                        r_beats    <= i_req_len;
                        if (w_oob)
                            r_state <= ERR;
                        else if (i_req_write)
                            r_state <= WRITE;
                        else
                            r_state <= RD_ISSUE;
                    end
                end
                WRITE: begin
                    if (w_wr_beat) begin
                        r_cur_addr <= r_cur_addr + 32'd1;
                        if (r_beats == 8'd0)
                            r_state <= DONE;
                        else
                            r_beats <= r_beats - 8'd1;
                    end
                end
                RD_ISSUE: r_state <= RD_DATA;
                RD_DATA: begin
                    if (w_rd_hs) begin
                        if (r_beats == 8'd0) begin
                            r_state <= DONE;
                        end else begin
                            r_cur_addr <= r_cur_addr + 32'd1;
                            r_beats    <= r_beats - 8'd1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_master.sv
// tb/tb_bram_master.sv - directed self-checking bench for bram_master with a synchronous BRAM model
module tb_bram_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        bram_en;
    logic        bram_rst;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [15:0] bram_wdata;
    logic [15:0] bram_rdata;

    logic [15:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    int d0, a0, h0;

    bram_master dut (
        .i_clk_BMST    (clk),
        .i_rst_BMST    (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .i_wdata_valid (wdata_valid),
        .o_wdata_ready (wdata_ready),
        .i_wdata       (wdata),
        .o_rdata_valid (rdata_valid),
        .i_rdata_ready (rdata_ready),
        .o_rdata       (rdata),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_bram_en     (bram_en),
        .o_bram_rst    (bram_rst),
        .o_bram_we     (bram_we),
        .o_bram_addr   (bram_addr),
        .o_bram_wdata  (bram_wdata),
        .i_bram_rdata  (bram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM: write-enable commits, plain enable loads the output register
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we == 4'b1111)
                mem[bram_addr[7:0]] <= bram_wdata;
            else
                bram_rdata <= mem[bram_addr[7:0]];
        end
    end

    // Event counters for done pulses, accepted requests and read handshakes
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (rdata_valid && rdata_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [31:0] a, input logic [7:0] l);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = l;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        wdata_valid = 0; wdata = 0; rdata_ready = 0;

        // reset state
        #3;
        check_eq("rst_req_ready", {31'd0, req_ready}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_bram_rst", {31'd0, bram_rst}, 1);
        check_eq("rst_bram_en", {31'd0, bram_en}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #2 check_eq("rel_req_ready_low", {31'd0, req_ready}, 0);
        check_eq("rel_bram_rst", {31'd0, bram_rst}, 0);
        tick();
        #2 check_eq("rel_req_ready_high", {31'd0, req_ready}, 1);

        // write burst 0x10 len 3
        set_req(1'b1, 32'h10, 8'd3);
        tick();
        req_valid = 0;
        #2 check_eq("wr_wdata_ready", {31'd0, wdata_ready}, 1);
        check_eq("wr_busy", {31'd0, busy}, 1);
        check_eq("wr_req_ready", {31'd0, req_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1'b1;
            wdata = 16'hA1 + 16'(i);
            #2;
            check_eq("wr_en", {31'd0, bram_en}, 1);
            check_eq("wr_we", {28'd0, bram_we}, 32'hF);
            check_eq("wr_addr", bram_addr, 32'h10 + i);
            check_eq("wr_wdata", {16'd0, bram_wdata}, 32'hA1 + i);
            tick();
        end
        wdata_valid = 0;
        #2 check_eq("wr_done", {31'd0, done}, 1);
        check_eq("wr_done_en", {31'd0, bram_en}, 0);
        tick();
        #2 check_eq("wr_done_clear", {31'd0, done}, 0);
        check_eq("wr_idle_ready", {31'd0, req_ready}, 1);
        check_eq("mem_10", {16'd0, mem[8'h10]}, 32'hA1);
        check_eq("mem_13", {16'd0, mem[8'h13]}, 32'hA4);

        // read burst 0x10 len 3, consumer always ready
        set_req(1'b0, 32'h10, 8'd3);
        rdata_ready = 1'b1;
        tick();
        req_valid = 0;
        #2 check_eq("rd_issue_valid", {31'd0, rdata_valid}, 0);
        check_eq("rd_issue_en", {31'd0, bram_en}, 1);
        check_eq("rd_issue_we", {28'd0, bram_we}, 0);
        check_eq("rd_issue_addr", bram_addr, 32'h10);
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("rd_valid", {31'd0, rdata_valid}, 1);
            check_eq("rd_data", {16'd0, rdata}, 32'hA1 + i);
            check_eq("rd_prefetch_en", {31'd0, bram_en}, (i < 3) ? 1 : 0);
            tick();
        end
        #2 check_eq("rd_done", {31'd0, done}, 1);
        tick();

        // read len 1 with a 5-cycle stall on beat 0
        h0 = hs_cnt;
        set_req(1'b0, 32'h12, 8'd1);
        rdata_ready = 1'b0;
        tick();
        req_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #2;
            check_eq("stall_data", {16'd0, rdata}, 32'hA3);
            check_eq("stall_en", {31'd0, bram_en}, 0);
            tick();
        end
        rdata_ready = 1'b1;
        #2 check_eq("stall_rel_en", {31'd0, bram_en}, 1);
        check_eq("stall_rel_addr", bram_addr, 32'h13);
        tick();
        #2 check_eq("stall_beat1", {16'd0, rdata}, 32'hA4);
        check_eq("stall_last_en", {31'd0, bram_en}, 0);
        tick();
        #2 check_eq("stall_done", {31'd0, done}, 1);
        tick();
        check_eq("stall_beats", hs_cnt - h0, 2);

        // reset during beat 2 of a 4-beat write
        d0 = done_cnt;
        set_req(1'b1, 32'h10, 8'd3);
        tick();
        req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1;
            wdata = 16'hC1 + 16'(i);
            tick();
        end
        wdata = 16'hC3;
        #2 check_eq("mid_addr", bram_addr, 32'h12);
        rst_n = 1'b0;
        #1;
        check_eq("mid_en", {31'd0, bram_en}, 0);
        check_eq("mid_we", {28'd0, bram_we}, 0);
        check_eq("mid_busy", {31'd0, busy}, 0);
        check_eq("mid_wdata_ready", {31'd0, wdata_ready}, 0);
        check_eq("mid_bram_rst", {31'd0, bram_rst}, 1);
        tick();
        tick();
        rst_n = 1'b1;
        wdata_valid = 0;
        #2 check_eq("mid_rel_low", {31'd0, req_ready}, 0);
        tick();
        #2 check_eq("mid_rel_high", {31'd0, req_ready}, 1);
        check_eq("mid_no_done", done_cnt - d0, 0);
        check_eq("mid_mem_10", {16'd0, mem[8'h10]}, 32'hC1);
        check_eq("mid_mem_11", {16'd0, mem[8'h11]}, 32'hC2);
        check_eq("mid_mem_12", {16'd0, mem[8'h12]}, 32'hA3);

        // request held high: one accept per IDLE visit (4-cycle read bursts)
        a0 = acc_cnt;
        d0 = done_cnt;
        set_req(1'b0, 32'h10, 8'd0);
        rdata_ready = 1'b1;
        repeat (12) tick();
        req_valid = 0;
        check_eq("held_accepts", acc_cnt - a0, 3);
        check_eq("held_dones", done_cnt - d0, 3);

`ifdef BRAM_MASTER_BOUNDS_EN
        set_req(1'b1, 32'd81919, 8'd1);
        tick();
        req_valid = 0;
        #2 check_eq("oob_err", {31'd0, err}, 1);
        check_eq("oob_en", {31'd0, bram_en}, 0);
        tick();
        #2 check_eq("oob_err_clear", {31'd0, err}, 0);
        check_eq("oob_no_done", {31'd0, done}, 0);
        check_eq("oob_ready", {31'd0, req_ready}, 1);
        set_req(1'b1, 32'd81919, 8'd0);
        tick();
        req_valid = 0;
        wdata_valid = 1'b1;
        wdata = 16'h5A;
        #2 check_eq("edge_en", {31'd0, bram_en}, 1);
        check_eq("edge_addr", bram_addr, 32'd81919);
        tick();
        wdata_valid = 0;
        #2 check_eq("edge_done", {31'd0, done}, 1);
        tick();
`else
        set_req(1'b1, 32'hFFFF_FFFF, 8'd1);
        tick();
        req_valid = 0;
        wdata_valid = 1'b1;
        wdata = 16'hD1;
        #2 check_eq("wrap_addr0", bram_addr, 32'hFFFF_FFFF);
        tick();
        wdata = 16'hD2;
        #2 check_eq("wrap_addr1", bram_addr, 32'h0);
        check_eq("wrap_err", {31'd0, err}, 0);
        tick();
        wdata_valid = 0;
        #2 check_eq("wrap_done", {31'd0, done}, 1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
